// File: rtl/dram_arbiter.sv
// Round-robin arbiter that shares the DRAM controller command port between the
// fetch and data ports, sequencing each transfer and guarding it with a watchdog.
module dram_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        d_req,
  input  logic        i_we,
  input  logic        d_we,
  input  logic [1:0]  i_beats,
  input  logic [1:0]  d_beats,
  input  logic [63:0] i_addr,
  input  logic [63:0] d_addr,
  input  logic [63:0] i_wdata,
  input  logic [63:0] d_wdata,
  output logic        i_ack,
  output logic        d_ack,
  output logic        i_err,
  output logic        d_err,
  output logic [63:0] i_rdata,
  output logic [63:0] d_rdata,
  output logic [2:0]  dm_rd_ctrl,
  output logic [2:0]  dm_wr_ctrl,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_din,
  input  logic [63:0] dm_dout,
  input  logic [1:0]  dram_state,
  output logic        busy,
  output logic        grant_id
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] DS_IDLE = 2'b00;

  // The controller leaves stale bits above the shifted-in beats.
  function automatic logic [63:0] rd_mask(input logic [1:0] beats);
    logic [63:0] m;
    case (beats)
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      2'd3:    m = 64'h0000_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] din_align(input logic [63:0] wdata, input logic [1:0] beats);
    logic [63:0] d;
    case (beats)
      2'd1:    d = {wdata[15:0], 48'h0000_0000_0000};
      2'd2:    d = {wdata[31:0], 32'h0000_0000};
      2'd3:    d = {wdata[47:0], 16'h0000};
      default: d = 64'h0000_0000_0000_0000;
    endcase
    return d;
  endfunction

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            we_q;
  logic [1:0]      beats_q;
  logic [63:0]     addr_q;
  logic [63:0]     wdata_q;
  logic            i_ack_q, d_ack_q, i_err_q, d_err_q;
  logic [63:0]     i_rdata_q, d_rdata_q;

  logic            pick_s;
  logic            grant_en_s;
  logic            sel_we_s;
  logic [1:0]      sel_beats_s;
  logic [63:0]     sel_addr_s;
  logic [63:0]     sel_wdata_s;
  logic            timeout_s;
  logic            active_s;
  logic            fin_s;
  logic            err_s;
  logic [63:0]     rdata_s;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    pick_s = 1'b0;
    if (i_req && d_req) begin
      pick_s = ~grant_q;
    end else if (d_req) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  assign grant_en_s  = (state_q == ST_IDLE) && (i_req || d_req);
  assign sel_we_s    = pick_s ? d_we    : i_we;
  assign sel_beats_s = pick_s ? d_beats : i_beats;
  assign sel_addr_s  = pick_s ? d_addr  : i_addr;
  assign sel_wdata_s = pick_s ? d_wdata : i_wdata;

  assign timeout_s = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (wd_q == WD_LAST);

  // Command is gated combinationally so it drops the cycle the controller returns to idle.
  assign active_s = ((state_q == ST_ISSUE) ||
                     ((state_q == ST_WAIT) && (dram_state != DS_IDLE))) && !timeout_s;

  assign dm_wr_ctrl = (active_s && we_q)  ? {1'b0, beats_q} : 3'd0;
  assign dm_rd_ctrl = (active_s && !we_q) ? {1'b0, beats_q} : 3'd0;
  assign busy       = (state_q != ST_IDLE);
  assign dm_addr    = busy ? addr_q : 64'd0;
  assign dm_din     = din_align(wdata_q, beats_q);
  assign grant_id   = grant_q;

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_err   = i_err_q;
  assign d_err   = d_err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  // Sequencer next-state, watchdog and completion result.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    fin_s   = 1'b0;
    err_s   = 1'b0;
    rdata_s = 64'd0;
    case (state_q)
      ST_IDLE: begin
        if (grant_en_s) begin
          grant_d = pick_s;
          wd_d    = {WD_W{1'b0}};
          fin_s   = (sel_beats_s == 2'd0);
          err_s   = (sel_beats_s == 2'd0);
          state_d = (sel_beats_s == 2'd0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wd_d = wd_q + WD_ONE;
        if (timeout_s) begin
          state_d = ST_DONE;
          fin_s   = 1'b1;
          err_s   = 1'b1;
        end else if (dram_state != DS_IDLE) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        wd_d = wd_q + WD_ONE;
        if (dram_state == DS_IDLE) begin
          state_d = ST_DONE;
          fin_s   = 1'b1;
          err_s   = 1'b0;
          rdata_s = we_q ? 64'd0 : (dm_dout & rd_mask(beats_q));
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fin_s   = 1'b1;
          err_s   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, grant history and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      wd_q    <= {WD_W{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
    end
  end

  // Requester fields are captured once at grant and held for the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      beats_q <= 2'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
    end else if (grant_en_s) begin
      we_q    <= sel_we_s;
      beats_q <= sel_beats_s;
      addr_q  <= sel_addr_s;
      wdata_q <= sel_wdata_s;
    end else begin
      we_q    <= we_q;
      beats_q <= beats_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  // One-cycle acknowledge with error and read data for the granted port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= 64'd0;
      d_rdata_q <= 64'd0;
    end else begin
      i_ack_q   <= fin_s && !grant_d;
      d_ack_q   <= fin_s && grant_d;
      i_err_q   <= fin_s && !grant_d && err_s;
      d_err_q   <= fin_s && grant_d && err_s;
      i_rdata_q <= (fin_s && !grant_d) ? rdata_s : 64'd0;
      d_rdata_q <= (fin_s && grant_d)  ? rdata_s : 64'd0;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small behavioural DRAM controller model.
module tb_dram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, i_we, d_we;
  logic [1:0]  i_beats, d_beats;
  logic [63:0] i_addr, d_addr, i_wdata, d_wdata;
  logic        i_ack, d_ack, i_err, d_err;
  logic [63:0] i_rdata, d_rdata;
  logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
  logic [63:0] dm_addr, dm_din, dm_dout;
  logic [1:0]  dram_state;
  logic        busy, grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  dram_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .d_req(d_req), .i_we(i_we), .d_we(d_we),
    .i_beats(i_beats), .d_beats(d_beats),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_ack(i_ack), .d_ack(d_ack), .i_err(i_err), .d_err(d_err),
    .i_rdata(i_rdata), .d_rdata(d_rdata),
    .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
    .dram_state(dram_state), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: leaves IDLE the cycle after a command, stays busy beats+1 cycles.
  logic [1:0]  cst;
  logic [2:0]  ccnt;
  logic [1:0]  cn;
  logic        stuck;
  logic [47:0] rd_pat;
  int          cmd_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst     <= 2'b00;
      ccnt    <= 3'd0;
      cn      <= 2'd0;
      dm_dout <= 64'hDEAD_BEEF_CAFE_F00D;
    end else if (cst == 2'b00) begin
      if (dm_wr_ctrl != 3'd0) begin
        cst <= 2'b10; ccnt <= dm_wr_ctrl + 3'd1; cn <= dm_wr_ctrl[1:0];
      end else if (dm_rd_ctrl != 3'd0) begin
        cst <= 2'b01; ccnt <= dm_rd_ctrl + 3'd1; cn <= dm_rd_ctrl[1:0];
      end
    end else if (!stuck) begin
      if (ccnt == 3'd1) begin
        cst <= 2'b00;
        if (cst == 2'b01) begin
          case (cn)
            2'd1:    dm_dout <= {dm_dout[47:0], rd_pat[15:0]};
            2'd2:    dm_dout <= {dm_dout[31:0], rd_pat[31:0]};
            2'd3:    dm_dout <= {dm_dout[15:0], rd_pat[47:0]};
            default: dm_dout <= dm_dout;
          endcase
        end
      end else begin
        ccnt <= ccnt - 3'd1;
      end
    end
  end
  assign dram_state = cst;

  initial cmd_seen = 0;
  always @(negedge clk) begin
    if (dm_rd_ctrl != 3'd0 || dm_wr_ctrl != 3'd0) cmd_seen <= cmd_seen + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request on a port; the cycle of the triggering IDLE sample is cycle 0.
  task automatic xfer(input logic port, input logic we, input logic [1:0] beats,
                      input logic [63:0] addr, input logic [63:0] wdata, input int maxc,
                      output int ack_cyc, output logic [63:0] rdata, output logic err,
                      output int wrong);
    ack_cyc = -1; rdata = 64'd0; err = 1'b0; wrong = 0;
    if (port) begin
      d_we = we; d_beats = beats; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_we = we; i_beats = beats; i_addr = addr; i_wdata = wdata; i_req = 1'b1;
    end
    for (int c = 1; c <= maxc && ack_cyc < 0; c++) begin
      tick();
      if (port ? i_ack : d_ack) wrong++;
      if (port ? d_ack : i_ack) begin
        ack_cyc = c;
        rdata   = port ? d_rdata : i_rdata;
        err     = port ? d_err : i_err;
        if (port) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  int          ac, wr, nack, c0;
  int          acyc [4];
  logic [63:0] rd;
  logic        er;
  logic        exp_port;

  initial begin
    rst_n = 1'b0; stuck = 1'b0; rd_pat = 48'd0;
    i_req = 1'b0; d_req = 1'b0; i_we = 1'b0; d_we = 1'b0;
    i_beats = 2'd0; d_beats = 2'd0;
    i_addr = 64'd0; d_addr = 64'd0; i_wdata = 64'd0; d_wdata = 64'd0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_grant", grant_id, 1'b0);
    check_val("rst_cmd", {dm_rd_ctrl, dm_wr_ctrl}, 6'd0);
    check_val("rst_ack", {i_ack, d_ack, i_err, d_err}, 4'd0);
    check_val("rst_addr", dm_addr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch read, 2 beats
    rd_pat = 48'h0000_AAAA_BBBB;
    xfer(1'b0, 1'b0, 2'd2, 64'h0000_0000_0000_1000, 64'd0, 20, ac, rd, er, wr);
    check_val("frd_cyc", 64'(ac), 64'd6);
    check_val("frd_data", rd, 64'h0000_0000_AAAA_BBBB);
    check_val("frd_err", er, 1'b0);
    check_val("frd_dack", 64'(wr), 64'd0);

    // Data write, 3 beats, command held until controller returns to IDLE
    d_we = 1'b1; d_beats = 2'd3; d_addr = 64'h0000_0000_8000_0010;
    d_wdata = 64'h0000_1111_2222_3333; d_req = 1'b1;
    ac = -1;
    for (int c = 1; c <= 12 && ac < 0; c++) begin
      tick();
      if (c == 1) begin
        check_val("dwr_wr1", dm_wr_ctrl, 3'd3);
        check_val("dwr_rd1", dm_rd_ctrl, 3'd0);
        check_val("dwr_din", dm_din, 64'h1111_2222_3333_0000);
        check_val("dwr_addr", dm_addr, 64'h0000_0000_8000_0010);
        check_val("dwr_gid", grant_id, 1'b1);
      end
      if (c == 5) check_val("dwr_wr5", dm_wr_ctrl, 3'd3);
      if (c == 6) check_val("dwr_wr6", dm_wr_ctrl, 3'd0);
      if (d_ack) begin
        ac = c; er = d_err; rd = d_rdata; d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    check_val("dwr_cyc", 64'(ac), 64'd7);
    check_val("dwr_err", er, 1'b0);
    check_val("dwr_rdata", rd, 64'd0);
    tick();
    d_we = 1'b0;

    // Continuous requests from both ports after reset alternate, data first
    do_reset();
    rd_pat = 48'h0000_0000_1234;
    i_we = 1'b0; d_we = 1'b0; i_beats = 2'd1; d_beats = 2'd1;
    i_req = 1'b1; d_req = 1'b1;
    nack = 0;
    for (int c = 1; c <= 60 && nack < 4; c++) begin
      tick();
      if (i_ack || d_ack) begin
        exp_port = (nack % 2 == 0);
        check_val("rr_port", d_ack, exp_port);
        check_val("rr_both", i_ack & d_ack, 1'b0);
        check_val("rr_data", d_ack ? d_rdata : i_rdata, 64'h1234);
        acyc[nack] = c;
        nack++;
        if (nack == 4) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check_val("rr_count", 64'(nack), 64'd4);
    check_val("rr_first", 64'(acyc[0]), 64'd5);
    check_val("rr_last", 64'(acyc[3]), 64'd23);
    tick();

    // Illegal beat count never reaches the controller
    c0 = cmd_seen;
    xfer(1'b1, 1'b0, 2'd0, 64'h40, 64'h1, 10, ac, rd, er, wr);
    tick();
    check_val("ill_cyc", 64'(ac), 64'd1);
    check_val("ill_err", er, 1'b1);
    check_val("ill_rdata", rd, 64'd0);
    check_val("ill_cmd", 64'(cmd_seen - c0), 64'd0);

    // Controller stuck in READ trips the watchdog
    stuck = 1'b1;
    xfer(1'b0, 1'b0, 2'd1, 64'h80, 64'd0, 100, ac, rd, er, wr);
    check_val("wd_cyc", 64'(ac), 64'd65);
    check_val("wd_err", er, 1'b1);
    check_val("wd_rdata", rd, 64'd0);
    check_val("wd_cmd", {dm_rd_ctrl, dm_wr_ctrl}, 6'd0);
    stuck = 1'b0;
    repeat (4) tick();
    rd_pat = 48'h0000_0000_5678;
    xfer(1'b1, 1'b0, 2'd1, 64'hC0, 64'd0, 20, ac, rd, er, wr);
    check_val("wd_next_cyc", 64'(ac), 64'd5);
    check_val("wd_next_err", er, 1'b0);
    check_val("wd_next_data", rd, 64'h5678);

    // Reset during WAIT abandons the transfer
    d_we = 1'b0; d_beats = 2'd3; d_addr = 64'h100; d_wdata = 64'hFFFF; d_req = 1'b1;
    repeat (4) tick();
    check_val("rstw_busy_pre", busy, 1'b1);
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    check_val("rstw_busy", busy, 1'b0);
    check_val("rstw_gid", grant_id, 1'b0);
    check_val("rstw_cmd", {dm_rd_ctrl, dm_wr_ctrl}, 6'd0);
    check_val("rstw_addr", dm_addr, 64'd0);
    check_val("rstw_din", dm_din, 64'd0);
    check_val("rstw_ack", {i_ack, d_ack}, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_pat = 48'h0000_0000_9ABC;
    i_beats = 2'd1; d_beats = 2'd1; i_we = 1'b0; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    ac = -1; wr = 0;
    for (int c = 1; c <= 12 && ac < 0; c++) begin
      tick();
      if (i_ack) wr++;
      if (d_ack) ac = c;
    end
    i_req = 1'b0; d_req = 1'b0;
    check_val("rstw_first_cyc", 64'(ac), 64'd5);
    check_val("rstw_no_iack", 64'(wr), 64'd0);
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter and sequencer in front of the 16-bit external DRAM controller. It shares the controller's single command port (read/write beat count, address, write data) between the instruction-fetch port and the data-memory port. Arbitration is round-robin. For each granted request the block holds the command stable for the whole transfer, detects completion from the controller's state output, returns a one-cycle acknowledge with aligned read data, and aborts hung transfers with a watchdog.

## Interface
- TIMEOUT_CYCLES, 64: cycles in ISSUE+WAIT before abort; must be ≥ 8.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req, d_req  in  1  fetch/data request; held high until the matching ack.
- i_we, d_we  in  1  1 = write, 0 = read.
- i_beats, d_beats  in  2  16-bit beats; 1..3 legal, 0 illegal.
- i_addr, d_addr  in  64  byte address, passed through unchanged.
- i_wdata, d_wdata  in  64  write data; low 16·beats bits used.
- i_ack, d_ack  out  1  one-cycle completion pulse.
- i_err, d_err  out  1  valid with ack; 1 = illegal beats or timeout.
- i_rdata, d_rdata  out  64  valid with ack on reads; otherwise 0.
- dm_rd_ctrl, dm_wr_ctrl  out  3  beat count to the controller; 0 = no command.
- dm_addr  out  64  command address.
- dm_din  out  64  command write data.
- dm_dout  in  64  controller read shift register.
- dram_state  in  2  controller state: 00 IDLE, 01 READ, 10 WRITE.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  0 = fetch, 1 = data; owner of the current or last transfer.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last.
  - Reset grant history: data port wins the first tie.
- On grant:
  - Latch we, beats, addr and wdata; set grant_id.
  - beats==0: go to DONE with err=1 and never touch the controller.
  - Otherwise go to ISSUE.
- Command drive:
  - Active condition = (ISSUE) or (WAIT and dram_state≠IDLE).
  - While active, the latched beats go on dm_wr_ctrl if we=1, else on dm_rd_ctrl; the other is 0.
  - Gating is combinational, so the command drops in the same cycle the controller returns to IDLE. This prevents a re-trigger.
  - dm_addr = latched addr while busy, else 0.
  - dm_din = latched wdata << (64−16·beats). The first beat sent is the most-significant 16 bits of the 16·beats-bit quantity.
- ISSUE: go to WAIT when dram_state≠IDLE.
- WAIT: when dram_state==IDLE, capture rdata and go to DONE.
  - Reads: rdata = dm_dout with bits [63:16·beats] forced to 0; the controller does not clear stale upper bits.
  - Writes: rdata = 0.
- DONE:
  - Pulse ack of the granted port with err/rdata; hold rdata/err for that cycle only, 0 otherwise.
  - Next state IDLE; a new grant is possible in that IDLE cycle.
- Watchdog:
  - Counter cleared on grant, increments each cycle in ISSUE/WAIT.
  - On reaching TIMEOUT_CYCLES: drop the command (zero it), go to DONE with err=1, rdata=0.
- A request arriving while busy waits; requests are never dropped.
- Requester field changes after grant are ignored.

## Timing
- Reset (asynchronous, any state): state IDLE, all acks/errs 0, rdata 0, dm_* 0, busy 0, grant_id 0, history = data wins next tie, watchdog 0.
  - Reset mid-transfer abandons the transfer with no ack.
- Request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1; controller leaves IDLE at cycle 2.
  - WAIT from cycle 3; controller back in IDLE at cycle n+3.
  - Ack at cycle n+4, for both reads and writes with n = beats.
- Illegal beats: ack with err at cycle 1.
- Back-to-back: minimum gap between an ack and the next grant is 1 cycle (IDLE). A continuously requesting pair alternates grants.
- Simultaneous new request and ack on the same port: the ack cycle does not re-sample; the held req is seen in the following IDLE.

## Test plan
- Fetch read, beats=2, controller returns 0xAAAA then 0xBBBB → i_ack at cycle 6, i_rdata=0x00000000AAAABBBB, i_err=0, d_ack never.
- Data write, beats=3, wdata=0x0000_1111_2222_3333, addr=0x80000010 → dm_din=0x1111222233330000, dm_wr_ctrl=3 until the controller returns to IDLE, then 0; d_ack at cycle 7.
- Both ports request continuously after reset → grant order data, fetch, data, fetch; each ack lands on the correct port.
- d_beats=0 → d_ack with d_err=1 at cycle 1; dm_rd_ctrl and dm_wr_ctrl stay 0 throughout.
- Controller model stuck in READ → ack with err=1 and rdata=0 after TIMEOUT_CYCLES; command zeroed; next request served normally.
- rst_n low during WAIT → all outputs 0 immediately; after release the data port wins the first tie and no stale ack appears.
